serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 139 +++++++++++++
 tb/tb_serial_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: captures a and b on start, adds one bit per
// clock LSB-first through a single full adder, then publishes sum/cout with
// a one-cycle done pulse. A WIDTH-bit add takes WIDTH RUN cycles.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset
//   start  begin an addition (accepted only when idle)
//   a, b   unsigned operands, sampled on the accepting edge
//   busy   high while bits are being processed
//   done   one-cycle completion pulse
//   sum    registered result, a+b mod 2^WIDTH
//   cout   registered carry-out
`timescale 1ns/1ps
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               s_bit;
    logic               c_next;

    // Single full adder on the current LSBs.
    always_comb begin
        s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        c_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    psum_d  = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
                psum_d  = {s_bit, psum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = c_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = {s_bit, psum_q[WIDTH-1:1]};
                    cout_d  = c_next;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): directed vectors, start held
// through RUN, mid-RUN reset, and a corner/random sweep against a+b.
`timescale 1ns/1ps
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           ecnt     = 0;
    logic [W:0]   sb[$];
    logic [W-1:0] last_sum = '0;
    logic         prev_done = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Output monitor: every done pulse retires one scoreboard entry.
    always @(negedge clk) begin
        logic [W:0] exp;
        if (rst_n && done) begin
            check_eq("done_single", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                exp = sb.pop_front();
                check_eq("sum", {24'd0, sum}, {24'd0, exp[W-1:0]});
                check_eq("cout", {31'd0, cout}, {31'd0, exp[W]});
                last_sum = exp[W-1:0];
            end
        end
        prev_done = rst_n ? done : 1'b0;
    end

    // Bounded wait for done; returns the edge index it followed.
    task automatic wait_done(output int ed);
        ed = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ed = ecnt;
                return;
            end
        end
        check_eq("timeout", 32'd0, 32'd1);
    endtask

    // One operation; operands are scrambled during RUN to show they were captured.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        int   e0;
        int   nb;
        logic got;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        e0 = ecnt + 1;
        sb.push_back((W+1)'(av) + (W+1)'(bv));
        nb  = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            if (busy) begin
                if (nb == 0) check_eq("sum_hold", {24'd0, sum}, {24'd0, last_sum});
                nb++;
            end
            if (done) begin
                got = 1'b1;
                check_eq("latency", ecnt - e0, W);
            end
        end
        if (!got) check_eq("timeout", 32'd0, 32'd1);
        check_eq("busy_cycles", nb, W);
    endtask

    initial begin
        int d1;
        int d2;
        int e0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_sum",  {24'd0, sum},  32'd0);
        check_eq("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors.
        run_op(8'h00, 8'h00);
        run_op(8'h0F, 8'h01);
        repeat (3) @(negedge clk);
        check_eq("idle_hold_sum", {24'd0, sum}, 32'h10);
        run_op(8'hFF, 8'h01);
        run_op(8'hFF, 8'hFF);
        run_op(8'hA5, 8'h5A);

        // Start held through RUN: ignored until IDLE, re-accepted at edge +10.
        @(negedge clk);
        a = 8'h3C;
        b = 8'h42;
        start = 1'b1;
        e0 = ecnt + 1;
        sb.push_back(9'h07E);
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        wait_done(d1);
        check_eq("held_latency1", d1 - e0, 8);
        sb.push_back(9'h1FE);
        @(negedge clk);
        check_eq("no_restart_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_eq("restart_busy", {31'd0, busy}, 32'd1);
        wait_done(d2);
        check_eq("held_latency2", d2 - e0, 18);
        @(negedge clk);

        // Reset after bit 4 aborts the operation.
        @(negedge clk);
        a = 8'hFF;
        b = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_sum",  {24'd0, sum},  32'd0);
        check_eq("abort_cout", {31'd0, cout}, 32'd0);
        last_sum = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("post_abort_sum",  {24'd0, sum},  32'd0);
        check_eq("post_abort_cout", {31'd0, cout}, 32'd0);
        check_eq("post_abort_busy", {31'd0, busy}, 32'd0);
        run_op(8'h80, 8'h80);

        // Corner rows plus random pairs.
        for (int i = 0; i < 256; i++) begin
            run_op(W'(i), 8'h00);
            run_op(W'(i), 8'h01);
            run_op(8'hFF, W'(i));
        end
        for (int i = 0; i < 2500; i++) run_op(W'($urandom), W'($urandom));

        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
